// File: rtl/byte_bus_memory.sv
// Word-organised memory target on the 8-bit time-multiplexed handler bus.
// Runs a 10-phase frame counter in lockstep with the handler; reads return MSB-first.
module byte_bus_memory #(
  parameter int unsigned AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_byte_i,
  input  logic [7:0] wdata_byte_i,
  output logic [7:0] rdata_byte_o,
  output logic       rdata_oe_o,
  output logic [3:0] phase_o,
  output logic       wr_pulse_o,
  output logic       rd_pulse_o,
  output logic       oob_o
);

  localparam int unsigned DW         = 32;
  localparam int unsigned DEPTH      = 2 ** AW;
  localparam logic [3:0]  LAST_PHASE = 4'd9;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [23:0]   rd_shift;

  logic [AW-1:0] index_c;
  logic          oob_c;
  logic [DW-1:0] rd_word_c;
  logic          unused_addr_lsb_c;

  // Word decode from the assembled byte address; the byte offset is don't-care.
  assign index_c           = addr_q[AW+1:2];
  assign oob_c             = |addr_q[DW-1:AW+2];
  assign rd_word_c         = oob_c ? '0 : mem[index_c];
  assign unused_addr_lsb_c = ^addr_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_o      <= '0;
      rdata_byte_o <= '0;
      rdata_oe_o   <= 1'b0;
      wr_pulse_o   <= 1'b0;
      rd_pulse_o   <= 1'b0;
      oob_o        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_shift     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      phase_o    <= (phase_o == LAST_PHASE) ? 4'd0 : 4'(phase_o + 4'd1);
      wr_pulse_o <= 1'b0;
      rd_pulse_o <= 1'b0;

      case (phase_o)
        4'd1: begin
          addr_q[7:0]  <= addr_byte_i;
          wdata_q[7:0] <= wdata_byte_i;
        end
        4'd2: begin
          addr_q[15:8]  <= addr_byte_i;
          wdata_q[15:8] <= wdata_byte_i;
        end
        4'd3: begin
          addr_q[23:16]  <= addr_byte_i;
          wdata_q[23:16] <= wdata_byte_i;
        end
        4'd4: begin
          addr_q[31:24]  <= addr_byte_i;
          wdata_q[31:24] <= wdata_byte_i;
        end
        // Direction byte: commit a write or launch a read.
        4'd5: begin
          if (addr_byte_i[0]) begin
            if (oob_c) begin
              oob_o <= 1'b1;
            end else begin
              mem[index_c] <= wdata_q;
              wr_pulse_o   <= 1'b1;
            end
          end else begin
            rd_pulse_o   <= 1'b1;
            rdata_oe_o   <= 1'b1;
            rdata_byte_o <= rd_word_c[31:24];
            rd_shift     <= rd_word_c[23:0];
            if (oob_c) begin
              oob_o <= 1'b1;
            end
          end
        end
        // Shift only in read frames so the pins stay quiet during writes.
        4'd6, 4'd7, 4'd8: begin
          if (rdata_oe_o) begin
            rdata_byte_o <= rd_shift[23:16];
            rd_shift     <= {rd_shift[15:0], 8'h00};
          end
        end
        4'd9: begin
          rdata_byte_o <= '0;
          rdata_oe_o   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_bus_memory.sv
// Bench for byte_bus_memory: acts as the handler, driving pins on the falling edge
// and comparing every phase of every frame against a word-array reference model.
module tb_byte_bus_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_byte_i;
  logic [7:0] wdata_byte_i;
  logic [7:0] rdata_byte_o;
  logic       rdata_oe_o;
  logic [3:0] phase_o;
  logic       wr_pulse_o;
  logic       rd_pulse_o;
  logic       oob_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [16];
  logic        ref_oob;

  byte_bus_memory #(.AW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_byte_i  (addr_byte_i),
    .wdata_byte_i (wdata_byte_i),
    .rdata_byte_o (rdata_byte_o),
    .rdata_oe_o   (rdata_oe_o),
    .phase_o      (phase_o),
    .wr_pulse_o   (wr_pulse_o),
    .rd_pulse_o   (rd_pulse_o),
    .oob_o        (oob_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] w, input int n);
    return 8'((w >> (8 * (3 - n))) & 32'hFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    ref_oob = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":phase"}, 32'(phase_o), 32'd0);
    check({tag, ":rdata"}, 32'(rdata_byte_o), 32'd0);
    check({tag, ":oe"}, 32'(rdata_oe_o), 32'd0);
    check({tag, ":wr_pulse"}, 32'(wr_pulse_o), 32'd0);
    check({tag, ":rd_pulse"}, 32'(rd_pulse_o), 32'd0);
    check({tag, ":oob"}, 32'(oob_o), 32'd0);
  endtask

  // One full handler frame; called at the falling edge of phase 0.
  task automatic run_frame(input logic [7:0] flag_byte, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    logic        wr;
    logic        in_range;
    logic [31:0] rword;
    logic        rd_active;
    string       t;
    wr       = flag_byte[0];
    in_range = (addr < 32'd64);
    rword    = in_range ? ref_mem[addr / 4] : 32'h0;
    for (int p = 0; p < 10; p++) begin
      if (p == 6) begin
        if (!in_range) ref_oob = 1'b1;
        else if (wr) ref_mem[addr / 4] = wdata;
      end
      rd_active = !wr && (p >= 6);
      t = $sformatf("%s:p%0d", tag, p);
      check({t, ":phase"}, 32'(phase_o), 32'(p));
      check({t, ":wr_pulse"}, 32'(wr_pulse_o), 32'(p == 6 && wr && in_range));
      check({t, ":rd_pulse"}, 32'(rd_pulse_o), 32'(p == 6 && !wr));
      check({t, ":oe"}, 32'(rdata_oe_o), 32'(rd_active));
      check({t, ":rdata"}, 32'(rdata_byte_o), rd_active ? 32'(get_byte(rword, p - 6)) : 32'd0);
      check({t, ":oob"}, 32'(oob_o), 32'(ref_oob));
      if (p >= 1 && p <= 4) begin
        addr_byte_i  = get_byte(addr, 4 - p);
        wdata_byte_i = get_byte(wdata, 4 - p);
      end else if (p == 5) begin
        addr_byte_i  = flag_byte;
        wdata_byte_i = 8'($urandom);
      end else begin
        addr_byte_i  = 8'($urandom);
        wdata_byte_i = 8'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic write_frame(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    run_frame(8'h01 | 8'($urandom & 32'hFE), addr, wdata, tag);
  endtask

  task automatic read_frame(input logic [31:0] addr, input string tag);
    run_frame(8'($urandom & 32'hFE), addr, $urandom, tag);
  endtask

  initial begin
    rst          = 1'b1;
    addr_byte_i  = 8'h00;
    wdata_byte_i = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    write_frame(32'h0000_0008, 32'hDEAD_BEEF, "wr_deadbeef");
    read_frame(32'h0000_0008, "rd_deadbeef");
    run_frame(8'hFE, 32'h0000_000B, 32'h0, "rd_alias");

    write_frame(32'h0000_0100, 32'h1234_5678, "wr_oob");
    read_frame(32'h0000_0100, "rd_oob");
    for (int i = 0; i < 16; i++) read_frame(32'(i * 4), $sformatf("sweep%0d", i));

    // Reset lands on the phase-3 edge of a write to word 1.
    for (int p = 0; p < 4; p++) begin
      addr_byte_i  = (p == 1) ? 8'h04 : 8'h00;
      wdata_byte_i = 8'hA5;
      if (p == 3) rst = 1'b1;
      @(negedge clk);
    end
    model_reset();
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    read_frame(32'h0000_0004, "rd_after_reset");
    read_frame(32'h0000_0008, "rd_cleared");
    write_frame(32'h0000_0004, 32'hCAFE_F00D, "wr_clean");
    read_frame(32'h0000_0004, "rd_clean");

    write_frame(32'h0000_0000, 32'h1111_1111, "b2b_wr1");
    read_frame(32'h0000_0000, "b2b_rd1");
    write_frame(32'h0000_0000, 32'h2222_2222, "b2b_wr2");
    read_frame(32'h0000_0000, "b2b_rd2");

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) write_frame(a, $urandom, $sformatf("rnd_wr%0d", n));
      else read_frame(a, $sformatf("rnd_rd%0d", n));
    end
    for (int i = 0; i < 16; i++) read_frame(32'(i * 4), $sformatf("final%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
